// File: rtl/countdown_bar.sv
// Round countdown timer with LED time bar: 1 Hz prescaler, seconds counter,
// thermometer bar that empties one segment per SEG seconds and blinks near the end.
module countdown_bar #(
  parameter int CLK_HZ        = 50_000_000,
  parameter int GAME_SECONDS  = 60,
  parameter int NUM_LEDS      = 6,
  parameter int BLINK_SECONDS = 10,
  parameter int TIME_W        = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                pause,
  output logic [TIME_W-1:0]   time_left,
  output logic [NUM_LEDS-1:0] bar_leds,
  output logic                running,
  output logic                expired
);

  localparam int SEG   = GAME_SECONDS / NUM_LEDS;
  localparam int PRE_W = $clog2(CLK_HZ);
  localparam int LIT_W = $clog2(NUM_LEDS + 1);
  localparam int SUB_W = $clog2(SEG + 1);

  localparam logic [PRE_W-1:0]  PRE_LAST   = PRE_W'(CLK_HZ - 1);
  localparam logic [PRE_W-1:0]  PRE_HALF   = PRE_W'(CLK_HZ / 2);
  localparam logic [TIME_W-1:0] TIME_FULL  = TIME_W'(GAME_SECONDS);
  localparam logic [TIME_W-1:0] TIME_BLINK = TIME_W'(BLINK_SECONDS);
  localparam logic [LIT_W-1:0]  LIT_FULL   = LIT_W'(NUM_LEDS);
  localparam logic [SUB_W-1:0]  SUB_FULL   = SUB_W'(SEG);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSED, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [PRE_W-1:0]    pre_q, pre_d;
  logic [TIME_W-1:0]   time_left_q, time_left_d;
  logic [LIT_W-1:0]    lit_q, lit_d;
  logic [SUB_W-1:0]    sub_q, sub_d;
  logic [NUM_LEDS-1:0] bar_leds_q, bar_leds_d;
  logic                running_q, running_d;
  logic                expired_q, expired_d;
  logic                blink_on;

  function automatic logic [TIME_W-1:0] dec_time(input logic [TIME_W-1:0] v);
    return (v == '0) ? v : v - TIME_W'(1);
  endfunction

  function automatic logic [LIT_W-1:0] dec_lit(input logic [LIT_W-1:0] v);
    return (v == '0) ? v : v - LIT_W'(1);
  endfunction

  function automatic logic [SUB_W-1:0] dec_sub(input logic [SUB_W-1:0] v);
    return (v <= SUB_W'(1)) ? SUB_W'(1) : v - SUB_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pre_q       <= '0;
      time_left_q <= '0;
      lit_q       <= '0;
      sub_q       <= SUB_FULL;
      bar_leds_q  <= '0;
      running_q   <= 1'b0;
      expired_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pre_q       <= pre_d;
      time_left_q <= time_left_d;
      lit_q       <= lit_d;
      sub_q       <= sub_d;
      bar_leds_q  <= bar_leds_d;
      running_q   <= running_d;
      expired_q   <= expired_d;
    end
  end

  // start overrides everything; pause is checked before the tick so a paused
  // cycle never consumes a prescaler step.
  always_comb begin
    state_d     = state_q;
    pre_d       = pre_q;
    time_left_d = time_left_q;
    lit_d       = lit_q;
    sub_d       = sub_q;
    expired_d   = 1'b0;
    if (start) begin
      state_d     = S_RUN;
      pre_d       = '0;
      time_left_d = TIME_FULL;
      lit_d       = LIT_FULL;
      sub_d       = SUB_FULL;
    end else begin
      case (state_q)
        S_RUN: begin
          if (pause) begin
            state_d = S_PAUSED;
          end else if (pre_q == PRE_LAST) begin
            pre_d       = '0;
            time_left_d = dec_time(time_left_q);
            if (sub_q == SUB_W'(1)) begin
              lit_d = dec_lit(lit_q);
              sub_d = SUB_FULL;
            end else begin
              sub_d = dec_sub(sub_q);
            end
            if (time_left_q == TIME_W'(1)) begin
              state_d   = S_DONE;
              expired_d = 1'b1;
              lit_d     = '0;
            end
          end else begin
            pre_d = pre_q + PRE_W'(1);
          end
        end
        S_PAUSED: begin
          if (!pause) state_d = S_RUN;
        end
        default: ;
      endcase
    end
  end

  // Outputs are derived from next-state values so the registered bar, running
  // and blink mask line up with the counters in the same cycle.
  always_comb begin
    running_d  = (state_d == S_RUN) || (state_d == S_PAUSED);
    blink_on   = running_d && (time_left_d != '0) && (time_left_d <= TIME_BLINK) &&
                 (pre_d >= PRE_HALF);
    bar_leds_d = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      bar_leds_d[i] = (LIT_W'(i) < lit_d) && !(blink_on && ((LIT_W'(i) + LIT_W'(1)) == lit_d));
    end
  end

  assign time_left = time_left_q;
  assign bar_leds  = bar_leds_q;
  assign running   = running_q;
  assign expired   = expired_q;

endmodule

// File: tb/tb_countdown_bar.sv
// Self-checking bench for countdown_bar with small parameters; the reference
// model tracks elapsed run cycles and derives time, prescaler and bar arithmetically.
module tb_countdown_bar;

  localparam int CLK_HZ = 4;
  localparam int GS     = 12;
  localparam int NL     = 6;
  localparam int BL     = 4;
  localparam int TW     = 8;
  localparam int SEG    = GS / NL;
  localparam int TOTAL  = GS * CLK_HZ;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          pause = 1'b0;
  logic [TW-1:0] time_left;
  logic [NL-1:0] bar_leds;
  logic          running;
  logic          expired;

  int checks = 0;
  int errors = 0;

  // Model: 0 idle, 1 run, 2 paused, 3 done; m_elapsed = cycles of progress in the round.
  int m_st = 0;
  int m_elapsed = TOTAL;
  bit m_exp = 1'b0;

  countdown_bar #(
    .CLK_HZ(CLK_HZ), .GAME_SECONDS(GS), .NUM_LEDS(NL), .BLINK_SECONDS(BL), .TIME_W(TW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pause(pause),
    .time_left(time_left), .bar_leds(bar_leds), .running(running), .expired(expired)
  );

  always #5 clk = ~clk;

  function automatic int m_time();
    return GS - m_elapsed / CLK_HZ;
  endfunction

  function automatic int m_pre();
    return m_elapsed % CLK_HZ;
  endfunction

  function automatic logic [NL-1:0] model_bar();
    int t, lit;
    logic [NL-1:0] b;
    t   = m_time();
    lit = (t + SEG - 1) / SEG;
    b   = '0;
    for (int i = 0; i < lit; i++) b[i] = 1'b1;
    if ((m_st == 1 || m_st == 2) && t >= 1 && t <= BL && m_pre() >= CLK_HZ / 2) b[lit-1] = 1'b0;
    return b;
  endfunction

  function automatic logic [TW+NL+1:0] model_outs();
    return {TW'(m_time()), model_bar(), (m_st == 1 || m_st == 2), m_exp};
  endfunction

  task automatic model_reset();
    m_st = 0; m_elapsed = TOTAL; m_exp = 1'b0;
  endtask

  task automatic model_clock(input bit s, input bit p);
    m_exp = 1'b0;
    if (s) begin
      m_st = 1; m_elapsed = 0;
    end else if (m_st == 1) begin
      if (p) m_st = 2;
      else begin
        m_elapsed++;
        if (m_elapsed == TOTAL) begin m_st = 3; m_exp = 1'b1; end
      end
    end else if (m_st == 2 && !p) begin
      m_st = 1;
    end
  endtask

  task automatic step(input bit s, input bit p);
    start = s; pause = p;
    @(posedge clk);
    model_clock(s, p);
    #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++;
    if ({time_left, bar_leds, running, expired} !== '0) begin
      errors++;
      $display("FAIL reset_vals: got t=%0d bar=%b run=%b exp=%b want all zero", time_left, bar_leds, running, expired);
    end
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step(1'b0, 1'b0);
      checks++;
      if ({time_left, bar_leds, running, expired} !== {TW'(0), NL'(0), 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL idle c%0d: got t=%0d bar=%b run=%b exp=%b want 0/000000/0/0", c, time_left, bar_leds, running, expired);
      end
    end
  endtask

  task automatic test_countdown();
    step(1'b1, 1'b0);
    checks++;
    if ({time_left, bar_leds, running} !== {TW'(12), 6'b111111, 1'b1}) begin
      errors++;
      $display("FAIL start_load: got t=%0d bar=%b run=%b want 12/111111/1", time_left, bar_leds, running);
    end
    for (int c = 1; c <= 48; c++) begin
      step(1'b0, 1'b0);
      checks++;
      if ({time_left, bar_leds, running, expired} !== model_outs()) begin
        errors++;
        $display("FAIL countdown c%0d: got %h want %h", c, {time_left, bar_leds, running, expired}, model_outs());
      end
      if (c == 3 || c == 4) begin
        checks++;
        if (time_left !== TW'(c == 3 ? 12 : 11)) begin
          errors++;
          $display("FAIL first_tick c%0d: got %0d want %0d", c, time_left, (c == 3 ? 12 : 11));
        end
      end
      if (c == 8) begin
        checks++;
        if ({time_left, bar_leds} !== {TW'(10), 6'b011111}) begin
          errors++;
          $display("FAIL bar_step: got t=%0d bar=%b want 10/011111", time_left, bar_leds);
        end
      end
      if (c == 47 || c == 48) begin
        checks++;
        if ({time_left, running, expired} !== (c == 47 ? {TW'(1), 1'b1, 1'b0} : {TW'(0), 1'b0, 1'b1})) begin
          errors++;
          $display("FAIL expiry c%0d: got t=%0d run=%b exp=%b", c, time_left, running, expired);
        end
      end
    end
    for (int c = 0; c < 3; c++) begin
      step(1'b0, 1'b0);
      checks++;
      if ({time_left, bar_leds, running, expired} !== {TW'(0), 6'b000000, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL done_hold c%0d: got t=%0d bar=%b run=%b exp=%b want 0/000000/0/0", c, time_left, bar_leds, running, expired);
      end
    end
  endtask

  task automatic test_blink();
    int seen;
    logic [NL-1:0] want;
    seen = 0;
    step(1'b1, 1'b0);
    for (int c = 0; c < 60; c++) begin
      step(1'b0, 1'b0);
      checks++;
      if ({time_left, bar_leds, running, expired} !== model_outs()) begin
        errors++;
        $display("FAIL blink_model c%0d: got %h want %h", c, {time_left, bar_leds, running, expired}, model_outs());
      end
      if (m_st == 1 && (m_time() == 4 || m_time() == 1)) begin
        if (m_time() == 4) want = (m_pre() < 2) ? 6'b000011 : 6'b000001;
        else               want = (m_pre() < 2) ? 6'b000001 : 6'b000000;
        seen++;
        checks++;
        if (bar_leds !== want) begin
          errors++;
          $display("FAIL blink t=%0d pre=%0d: got %b want %b", m_time(), m_pre(), bar_leds, want);
        end
      end
    end
    checks++;
    if (seen != 8) begin
      errors++;
      $display("FAIL blink_count: got %0d want 8", seen);
    end
  endtask

  task automatic test_pause();
    bit found;
    int n;
    found = 1'b0;
    step(1'b1, 1'b0);
    for (int c = 0; c < 60 && !found; c++) begin
      step(1'b0, 1'b0);
      if (m_time() == 7 && m_pre() == 1) found = 1'b1;
    end
    checks++;
    if (!found || time_left !== TW'(7)) begin
      errors++;
      $display("FAIL pause_reach: got t=%0d want 7", time_left);
    end
    for (int c = 0; c < 10; c++) begin
      step(1'b0, 1'b1);
      checks++;
      if ({time_left, bar_leds, running, expired} !== {TW'(7), 6'b001111, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL pause_frozen c%0d: got t=%0d bar=%b run=%b exp=%b want 7/001111/1/0", c, time_left, bar_leds, running, expired);
      end
    end
    // The release cycle only returns to RUN; the held prescaler value 1 then needs three RUN cycles.
    step(1'b0, 1'b0);
    n = 0;
    for (int c = 0; c < 10 && time_left == TW'(7); c++) begin
      step(1'b0, 1'b0);
      n++;
      checks++;
      if ({time_left, bar_leds, running, expired} !== model_outs()) begin
        errors++;
        $display("FAIL resume_model c%0d: got %h want %h", c, {time_left, bar_leds, running, expired}, model_outs());
      end
    end
    checks++;
    if (n != 3 || time_left !== TW'(6)) begin
      errors++;
      $display("FAIL resume_tick: got %0d cycles t=%0d want 3 cycles t=6", n, time_left);
    end
  endtask

  task automatic test_restart();
    bit done;
    step(1'b1, 1'b0);
    for (int c = 0; c < 60 && m_time() != 3; c++) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    checks++;
    if ({time_left, bar_leds, running, expired} !== {TW'(12), 6'b111111, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL restart_run: got t=%0d bar=%b run=%b exp=%b want 12/111111/1/0", time_left, bar_leds, running, expired);
    end
    done = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      step(1'b0, 1'b0);
      if (expired === 1'b1) done = 1'b1;
    end
    checks++;
    if (!done || m_st != 3) begin
      errors++;
      $display("FAIL restart_expire: got expired seen=%0d want 1", done);
    end
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    checks++;
    if ({time_left, bar_leds, running, expired} !== {TW'(12), 6'b111111, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL restart_done: got t=%0d bar=%b run=%b exp=%b want 12/111111/1/0", time_left, bar_leds, running, expired);
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 1'b0);
    for (int c = 0; c < 60 && m_time() != 5; c++) step(1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({time_left, bar_leds, running, expired} !== '0) begin
      errors++;
      $display("FAIL async_reset: got t=%0d bar=%b run=%b exp=%b want all zero", time_left, bar_leds, running, expired);
    end
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step(1'b0, 1'b0);
      checks++;
      if ({time_left, bar_leds, running, expired} !== {TW'(0), 6'b000000, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL post_reset_idle c%0d: got t=%0d bar=%b run=%b exp=%b", c, time_left, bar_leds, running, expired);
      end
    end
    step(1'b1, 1'b0);
    checks++;
    if ({time_left, bar_leds, running, expired} !== model_outs()) begin
      errors++;
      $display("FAIL post_reset_start: got %h want %h", {time_left, bar_leds, running, expired}, model_outs());
    end
  endtask

  task automatic test_random();
    bit s, p;
    p = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      s = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 9) == 0) p = ~p;
      step(s, p);
      checks++;
      if ({time_left, bar_leds, running, expired} !== model_outs()) begin
        errors++;
        $display("FAIL random c%0d s=%0d p=%0d: got %h want %h", c, s, p, {time_left, bar_leds, running, expired}, model_outs());
      end
    end
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_blink();
    test_pause();
    test_restart();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
